// File: rtl/mux_arbiter_if.sv
// Request/output handshake bundle for mux_arbiter: four valid/ready requesters in, one valid/ready stream out.
// A word moves on any cycle where valid and ready are both high on the same side; valid never waits on ready.
interface mux_arbiter_if #(
  parameter int DATA_WIDTH = 32
);
  logic [3:0]            req_valid;
  logic [DATA_WIDTH-1:0] req_data_0;
  logic [DATA_WIDTH-1:0] req_data_1;
  logic [DATA_WIDTH-1:0] req_data_2;
  logic [DATA_WIDTH-1:0] req_data_3;
  logic [3:0]            req_ready;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic [1:0]            out_grant;
  logic                  out_ready;

  // Arbiter side
  modport slave (
    input  req_valid, req_data_0, req_data_1, req_data_2, req_data_3, out_ready,
    output req_ready, out_valid, out_data, out_grant
  );

  // Requester / consumer side
  modport master (
    output req_valid, req_data_0, req_data_1, req_data_2, req_data_3, out_ready,
    input  req_ready, out_valid, out_data, out_grant
  );
endinterface

// File: rtl/mux_arbiter.sv
// Round-robin 4-to-1 arbiter feeding a single-entry registered output buffer.
// Define MUX_ARBITER_FIXED_PRIORITY_EN to make the lowest requesting index always win.
module mux_arbiter #(
  parameter int DATA_WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  mux_arbiter_if.slave bus,
  output logic         dbg_state,
  output logic [1:0]   dbg_last_grant
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [1:0]            last_grant_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [1:0]            grant_q;

  logic                  load_ok;
  logic                  grant_valid;
  logic [1:0]            grant_idx;
  logic [DATA_WIDTH-1:0] sel_data;

  assign load_ok     = (state_q == EMPTY) || bus.out_ready;
  assign grant_valid = load_ok && (|bus.req_valid) && !reset;

`ifdef MUX_ARBITER_FIXED_PRIORITY_EN
  always_comb begin
    grant_idx = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      if (bus.req_valid[k]) grant_idx = k[1:0];
    end
  end
`else
  // Search starts just past the last winner; last_grant itself is tried last.
  always_comb begin
    logic [1:0] cand;
    logic       found;
    grant_idx = 2'd0;
    found     = 1'b0;
    cand      = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_grant_q + k[1:0];
      if (!found && bus.req_valid[cand]) begin
        grant_idx = cand;
        found     = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    sel_data = '0;
    case (grant_idx)
      2'd0: sel_data = bus.req_data_0;
      2'd1: sel_data = bus.req_data_1;
      2'd2: sel_data = bus.req_data_2;
      2'd3: sel_data = bus.req_data_3;
      default: sel_data = '0;
    endcase
  end

  always_comb begin
    bus.req_ready = 4'b0000;
    if (grant_valid) bus.req_ready = 4'b0001 << grant_idx;
  end

  always_comb begin
    state_d = state_q;
    if (grant_valid)                          state_d = FULL;
    else if (state_q == FULL && bus.out_ready) state_d = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= EMPTY;
      data_q       <= '0;
      grant_q      <= 2'd0;
      last_grant_q <= 2'd3;
    end else begin
      state_q <= state_d;
      if (grant_valid) begin
        data_q       <= sel_data;
        grant_q      <= grant_idx;
        last_grant_q <= grant_idx;
      end
    end
  end

  assign bus.out_valid  = (state_q == FULL);
  assign bus.out_data   = data_q;
  assign bus.out_grant  = grant_q;
  assign dbg_state      = state_q;
  assign dbg_last_grant = last_grant_q;
endmodule

// File: tb/tb_mux_arbiter.sv
// Directed bench for mux_arbiter: reset, round-robin order, single request, backpressure,
// drain-and-load in one cycle, and reset while the buffer is full.
module tb_mux_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic       dbg_state;
  logic [1:0] dbg_last_grant;
  int         checks = 0;
  int         errors = 0;

  mux_arbiter_if #(.DATA_WIDTH(32)) bus ();

  mux_arbiter #(.DATA_WIDTH(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .bus           (bus.slave),
    .dbg_state     (dbg_state),
    .dbg_last_grant(dbg_last_grant)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic v, input logic [31:0] d, input logic [1:0] g);
    check({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
    check({tag, "_data"},  bus.out_data, d);
    check({tag, "_grant"}, 32'(bus.out_grant), 32'(g));
  endtask

  task automatic set_base_data();
    bus.req_data_0 = 32'h1000_0000;
    bus.req_data_1 = 32'h1000_0001;
    bus.req_data_2 = 32'h1000_0002;
    bus.req_data_3 = 32'h1000_0003;
  endtask

  initial begin
    logic [1:0] exp_g;
    reset         = 1'b1;
    bus.req_valid = 4'b1111;
    bus.out_ready = 1'b0;
    set_base_data();

    // Reset held two cycles with every requester active
    for (int i = 0; i < 2; i++) begin
      tick();
      check("rst_ready", 32'(bus.req_ready), 32'h0);
      check_out("rst", 1'b0, 32'h0, 2'd0);
    end

    // Round-robin: all requesting, consumer always ready
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
`ifdef MUX_ARBITER_FIXED_PRIORITY_EN
      exp_g = 2'd0;
`else
      exp_g = 2'(i);
`endif
      #1;
      check("rr_ready", 32'(bus.req_ready), 32'(4'b0001 << exp_g));
      tick();
      check_out("rr", 1'b1, 32'h1000_0000 + 32'(exp_g), exp_g);
    end

    // Single request from requester 2
    bus.req_valid  = 4'b0100;
    bus.req_data_2 = 32'hDEAD_BEEF;
    #1;
    check("single_ready", 32'(bus.req_ready), 32'h4);
    tick();
    check_out("single", 1'b1, 32'hDEAD_BEEF, 2'd2);
    bus.req_valid = 4'b0000;
    set_base_data();
    #1;
    check("idle_ready", 32'(bus.req_ready), 32'h0);
    tick();
    check("drain_valid", 32'(bus.out_valid), 32'h0);

    // Fill from requester 1, then hold out_ready low with all requesting
    bus.req_valid  = 4'b0010;
    bus.req_data_1 = 32'hA5A5_A5A5;
    #1;
    check("fill_ready", 32'(bus.req_ready), 32'h2);
    tick();
    check_out("fill", 1'b1, 32'hA5A5_A5A5, 2'd1);
    set_base_data();
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_ready", 32'(bus.req_ready), 32'h0);
      tick();
      check_out("bp", 1'b1, 32'hA5A5_A5A5, 2'd1);
    end

    // Release: next winner after last_grant=1
`ifdef MUX_ARBITER_FIXED_PRIORITY_EN
    exp_g = 2'd0;
`else
    exp_g = 2'd2;
`endif
    bus.out_ready = 1'b1;
    #1;
    check("rel_ready", 32'(bus.req_ready), 32'(4'b0001 << exp_g));
    tick();
    check_out("rel", 1'b1, 32'h1000_0000 + 32'(exp_g), exp_g);

    // Drain and load in the same cycle, no bubble
    bus.req_valid = 4'b0010;
    #1;
    check("dl_ready", 32'(bus.req_ready), 32'h2);
    tick();
    check_out("dl", 1'b1, 32'h1000_0001, 2'd1);

    // Reset while FULL and stalled
    bus.out_ready = 1'b0;
    bus.req_valid = 4'b1111;
    reset         = 1'b1;
    #1;
    check("mid_rst_ready", 32'(bus.req_ready), 32'h0);
    tick();
    check_out("mid_rst", 1'b0, 32'h0, 2'd0);
    reset         = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    check("post_rst_ready", 32'(bus.req_ready), 32'h1);
    tick();
    check_out("post_rst", 1'b1, 32'h1000_0000, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mux_arbiter.md
# mux_arbiter

Round-robin arbiter and output stage that shares the team's 32-bit 4-to-1 selection datapath between four requesters. Each requester presents a word with a valid/ready handshake. The block picks one requester per transfer and drives the 2-bit selector for the chosen input. It registers the selected word into a single-entry output buffer with its own valid/ready handshake toward the downstream consumer.

## Interface
Parameters:
- DATA_WIDTH, 32, width of every request word and of out_data.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising edge of clk.
- req_valid  input  4  bit i: requester i presents req_data_i.
- req_data_0..req_data_3  input  DATA_WIDTH each  request words.
- req_ready  output  4  bit i: word from requester i accepted this cycle (one-hot or zero).
- out_valid  output  1  out_data holds an unconsumed word.
- out_data  output  DATA_WIDTH  registered selected word.
- out_grant  output  2  index of the requester whose word is in out_data.
- out_ready  input  1  downstream accepts out_data this cycle.

## Operation
- States: EMPTY (out_valid=0) and FULL (out_valid=1). The buffer is the only storage.
- load_ok = EMPTY or (FULL and out_ready). The arbiter grants only when load_ok=1 and at least one req_valid bit is set.
- Round-robin search order: last_grant+1, last_grant+2, last_grant+3, last_grant, all mod 4. The first set req_valid bit in that order wins.
- On grant g:
  - req_ready[g]=1 combinationally in the same cycle.
  - Selector=g internally.
  - Next edge: out_data<=req_data_g, out_grant<=g, last_grant<=g, state FULL.
- Transitions:
  - EMPTY with no request: stay EMPTY.
  - FULL with out_ready=0: hold. out_data and out_grant stay stable, req_ready=0.
  - FULL with out_ready=1 and no request: go EMPTY.
  - FULL with out_ready=1 and a request: reload, stay FULL. This gives back-to-back transfers at 1 word/cycle.
- req_ready is never asserted for a requester whose req_valid=0. At most one bit is set.
- Requesters must hold req_valid and req_data stable until their req_ready is seen. The block does not check this.
- A requester that drops req_valid before grant is skipped with no side effect. last_grant is unchanged.
- Reset mid-transfer: a word in the buffer is discarded (out_valid=0 next cycle). No req_ready is asserted during a cycle with reset=1.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_grant=0, req_ready=0.
  - Internal last_grant=3, so requester 0 has highest priority after reset.
- Latency: req_valid at cycle N with buffer empty gives req_ready at cycle N and out_valid=1 at cycle N+1.
- req_ready depends combinationally on req_valid, state and out_ready. No other path from input to output is combinational. out_* are flop outputs.
- Fairness: with all four requesting continuously and out_ready=1, grants go 0,1,2,3,0,… Each requester waits at most 3 transfers.

## Configuration
- MUX_ARBITER_FIXED_PRIORITY_EN:
  - Defined: fixed priority; the lowest index among set req_valid bits always wins, and last_grant is ignored (still updated for debug).
  - Undefined (default): round-robin as specified above.
  - All handshake and timing rules are identical in both modes.

## Test plan
- Reset: hold reset=1 for 2 cycles with req_valid=4'b1111 -> req_ready=0, out_valid=0, out_data=0, out_grant=0 throughout.
- Single request: req_valid=4'b0100, req_data_2=32'hDEAD_BEEF, out_ready=1 -> req_ready=4'b0100 same cycle; next cycle out_valid=1, out_data=32'hDEAD_BEEF, out_grant=2.
- Round-robin: all req_valid=1, data_i=32'h1000_000i, out_ready=1 for 8 cycles -> out_grant sequence 0,1,2,3,0,1,2,3 on consecutive cycles. With the macro defined -> out_grant stays 0 every cycle.
- Backpressure: buffer FULL with 32'hA5A5_A5A5, out_ready=0 for 5 cycles with requests pending -> out_data stable, req_ready=0. Releasing out_ready loads the next winner the following cycle.
- Simultaneous drain and load: FULL, out_ready=1, req_valid=4'b0010 -> req_ready=4'b0010 same cycle; out_valid stays 1 with new word next cycle, no bubble.
- Reset mid-operation: assert reset while FULL and out_ready=0 -> out_valid=0 next cycle; first grant after reset release goes to requester 0 when all request.
